// File: rtl/rv32_pkg.sv
// Shared RV32 core types for the register-file write path.
// Provides XLEN, REG_AW, the buffered-write entry type and an rd-match helper.
// Latency: n/a (types only). Backpressure: n/a.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // A live entry targeting rd; x0 never matches, so x0 lookups cannot hit.
  function automatic logic rd_hit(input wb_entry_t e, input logic [REG_AW-1:0] rd);
    return e.valid && (e.rd == rd) && (rd != '0);
  endfunction

endpackage

// File: rtl/rf_warb_buf.sv
// Pending-write circular buffer: DEPTH entries, per-entry valid, kill-by-rd, two lookup ports.
// Latency: push/pop/kill take effect at the next posedge; lookups and head are combinational.
// Backpressure: none internally; the owner must not push when count_o == DEPTH.
// Ports: clk/rst_n; push_i/push_rd_i/push_data_i append at tail; pop_i retires head;
//   kill_vld_i/kill_rd_i invalidate matching entries; head_o/count_o expose state;
//   lk_adN_i -> lk_hitN_o/lk_dataN_o associative lookups on pre-update state.
module rf_warb_buf
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [REG_AW-1:0]           push_rd_i,
  input  logic [XLEN-1:0]             push_data_i,
  input  logic                        pop_i,
  input  logic                        kill_vld_i,
  input  logic [REG_AW-1:0]           kill_rd_i,
  output wb_entry_t                   head_o,
  output logic [$clog2(DEPTH):0]      count_o,
  input  logic [REG_AW-1:0]           lk_ad1_i,
  input  logic [REG_AW-1:0]           lk_ad2_i,
  output logic                        lk_hit1_o,
  output logic [XLEN-1:0]             lk_data1_o,
  output logic                        lk_hit2_o,
  output logic [XLEN-1:0]             lk_data2_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         ent_q [DEPTH];
  wb_entry_t         ent_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  assign head_o  = ent_q[head_q];
  assign count_o = count_q;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    // Kills leave the slot occupied; the dead entry is retired later by a pop.
    // A new push supersedes any older entry for the same rd, keeping one live entry per rd.
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_vld_i && rd_hit(ent_q[i], kill_rd_i)) ent_d[i].valid = 1'b0;
      if (push_i && rd_hit(ent_q[i], push_rd_i))     ent_d[i].valid = 1'b0;
    end
    if (pop_i) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PW'(1);
    end
    // Push after pop: tail never equals head when both happen (count is 1..DEPTH-1 then).
    if (push_i) begin
      ent_d[tail_q] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
      tail_d        = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // At most one live entry per rd, so OR-merging matching data yields that entry (or 0).
  always_comb begin
    lk_hit1_o  = 1'b0;
    lk_data1_o = '0;
    lk_hit2_o  = 1'b0;
    lk_data2_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_hit(ent_q[i], lk_ad1_i)) begin
        lk_hit1_o  = 1'b1;
        lk_data1_o = lk_data1_o | ent_q[i].data;
      end
      if (rd_hit(ent_q[i], lk_ad2_i)) begin
        lk_hit2_o  = 1'b1;
        lk_data2_o = lk_data2_o | ent_q[i].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Sole driver of the register-file write port: merges WB results with long-latency results.
// Latency: 1 cycle from winning arbitration to registered rf_we/rf_ad/rf_wd.
// Backpressure: ld_ready = buffer not full (count only, no fall-through); WB is never stalled.
// Ports: wb_* in-order WB result; ld_valid/ld_ready/ld_rd/ld_data long-latency handshake;
//   rf_we/rf_ad/rf_wd registered write port; byp_adN -> byp_hitN/byp_dataN pending-write bypass.
// Optional: define RF_WARB_PERF_EN to add perf_collide/perf_full saturating cycle counters.
module rf_write_arbiter
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_ad,
  output logic [XLEN-1:0]   rf_wd,
  input  logic [REG_AW-1:0] byp_ad1,
  input  logic [REG_AW-1:0] byp_ad2,
  output logic              byp_hit1,
  output logic [XLEN-1:0]   byp_data1,
  output logic              byp_hit2,
  output logic [XLEN-1:0]   byp_data2
`ifdef RF_WARB_PERF_EN
  ,
  output logic [31:0]       perf_collide,
  output logic [31:0]       perf_full
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t         head;
  logic [CW-1:0]     count;
  logic              wb_wr, ld_xfer, ld_keep, buf_empty;
  logic              pop, push, direct;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_ad_q, rf_ad_d;
  logic [XLEN-1:0]   rf_wd_q, rf_wd_d;

  // Gated by rst_n so no handshake can complete while reset is asserted.
  assign ld_ready  = rst_n && (count < CW'(DEPTH));
  assign ld_xfer   = ld_valid && ld_ready;
  assign wb_wr     = wb_valid && (wb_rd != '0);
  assign buf_empty = (count == '0);
  // x0 results and results overwritten by a same-cycle (younger) WB are accepted and discarded.
  assign ld_keep   = ld_xfer && (ld_rd != '0) && !(wb_wr && (ld_rd == wb_rd));

  always_comb begin
    rf_we_d = 1'b0;
    rf_ad_d = '0;
    rf_wd_d = '0;
    pop     = 1'b0;
    direct  = 1'b0;
    if (wb_wr) begin
      rf_we_d = 1'b1;
      rf_ad_d = wb_rd;
      rf_wd_d = wb_data;
    end else if (!buf_empty) begin
      // A killed head burns the slot with no write rather than looking past it.
      pop = 1'b1;
      if (head.valid) begin
        rf_we_d = 1'b1;
        rf_ad_d = head.rd;
        rf_wd_d = head.data;
      end
    end else if (ld_keep) begin
      direct  = 1'b1;
      rf_we_d = 1'b1;
      rf_ad_d = ld_rd;
      rf_wd_d = ld_data;
    end
  end

  assign push = ld_keep && !direct;

  rf_warb_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_rd_i   (ld_rd),
    .push_data_i (ld_data),
    .pop_i       (pop),
    .kill_vld_i  (wb_wr),
    .kill_rd_i   (wb_rd),
    .head_o      (head),
    .count_o     (count),
    .lk_ad1_i    (byp_ad1),
    .lk_ad2_i    (byp_ad2),
    .lk_hit1_o   (byp_hit1),
    .lk_data1_o  (byp_data1),
    .lk_hit2_o   (byp_hit2),
    .lk_data2_o  (byp_data2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_ad_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_ad_q <= rf_ad_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_ad = rf_ad_q;
  assign rf_wd = rf_wd_q;

`ifdef RF_WARB_PERF_EN
  logic [31:0] perf_collide_q, perf_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_collide_q <= '0;
      perf_full_q    <= '0;
    end else begin
      // Collision: a result had to be buffered because WB owned the write port.
      if (wb_wr && push && (perf_collide_q != '1)) perf_collide_q <= perf_collide_q + 32'd1;
      if (ld_valid && !ld_ready && (perf_full_q != '1)) perf_full_q <= perf_full_q + 32'd1;
    end
  end

  assign perf_collide = perf_collide_q;
  assign perf_full    = perf_full_q;
`endif

endmodule
